// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Holds the pipeline via stall_req_ex while a division is in flight and
// presents quotient (LO) / remainder (HI) as a level-valid result.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             annul,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             stall_req_ex
);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend magnitude, quotient bits shift in at LSB
  logic [WIDTH-1:0] dsr_q, dsr_d;       // divisor magnitude
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             done_q, done_d;

  // One restoring step: shift in the next dividend bit and trial-subtract.
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] step_rem, step_dvd;

  assign shifted  = {rem_q, dvd_q[WIDTH-1]};
  assign trial    = shifted - {1'b0, dsr_q};
  // shifted < 2*divisor, so on a failed trial it still fits in WIDTH bits
  assign step_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign step_dvd = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};

  // Next-state and datapath updates; annul overrides everything at the end.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    remo_d    = remo_q;
    done_d    = done_q;

    case (state_q)
      S_IDLE: begin
        if (start && !annul) begin
          if (divisor == '0) begin
            // keep the raw dividend: it becomes the remainder untouched
            dvd_d   = dividend;
            state_d = S_BYZERO;
          end else begin
            dvd_d     = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
            dsr_d     = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;
            neg_quo_d = signed_div && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_d = signed_div && dividend[WIDTH-1];
            cnt_d     = '0;
            rem_d     = '0;
            state_d   = S_RUN;
          end
        end
      end
      S_BYZERO: begin
        quo_d   = '1;
        remo_d  = dvd_q;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_RUN: begin
        rem_d = step_rem;
        dvd_d = step_dvd;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          // sign-correct on the way into DONE; -2^(W-1)/-1 wraps naturally
          quo_d   = neg_quo_q ? -step_dvd : step_dvd;
          remo_d  = neg_rem_q ? -step_rem : step_rem;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (annul) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      quo_d   = quo_q;
      remo_d  = remo_q;
    end
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      remo_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      remo_q    <= remo_d;
      done_q    <= done_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = remo_q;
  assign done      = done_q;
  assign busy      = (state_q == S_BYZERO) || (state_q == S_RUN);

  // Stall request is combinational so reset and annul drop it without a clock.
  assign stall_req_ex = !rst && !annul &&
                        (((state_q == S_IDLE) && start) || busy);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: cycle-level reference model plus
// directed vectors with hand-computed results.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        annul;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;
  logic        busy;
  logic        stall_req_ex;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_div   (signed_div),
    .dividend     (dividend),
    .divisor      (divisor),
    .annul        (annul),
    .quotient     (quotient),
    .remainder    (remainder),
    .done         (done),
    .busy         (busy),
    .stall_req_ex (stall_req_ex)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: truncating division, remainder follows dividend.
  task automatic ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      if (sd) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endtask

  // Reference model: a division completes a fixed number of cycles after acceptance.
  bit          m_active, m_done;
  int          m_age, m_lat;
  logic [31:0] m_q, m_r, pq, pr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_done = 0; m_q = 0; m_r = 0;
    end else if (annul) begin
      m_active = 0; m_done = 0;
    end else if (m_active) begin
      m_age++;
      if (m_age == m_lat) begin
        m_active = 0; m_done = 1; m_q = pq; m_r = pr;
      end
    end else if (m_done) begin
      if (!start) m_done = 0;
    end else if (start) begin
      m_active = 1;
      m_age    = 1;
      m_lat    = (divisor == 32'd0) ? 2 : 33;
      ref_div(signed_div, dividend, divisor, pq, pr);
    end
  end

  // Compare process: every cycle on the falling edge.
  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = !rst && !annul && (m_active || (!m_done && start));
    check1("stall_req_ex", stall_req_ex, exp_stall);
    check1("busy", busy, m_active);
    check1("done", done, m_done);
    if (m_done) begin
      check32("quotient", quotient, m_q);
      check32("remainder", remainder, m_r);
    end
  end

  // Wait for done from the current (start) cycle, counting stall cycles.
  task automatic wait_result(input string name, input logic [31:0] eq, input logic [31:0] er,
                             input int estall, input bit scramble);
    int  n_stall = 0;
    bit  seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
      if (stall_req_ex) n_stall++;
      if (scramble && i == 3) begin
        dividend   = $urandom;
        divisor    = $urandom;
        signed_div = ~signed_div;
      end
    end
    check1({name, " done_seen"}, seen, 1'b1);
    check32({name, " stall_cycles"}, 32'(n_stall), 32'(estall));
    check32({name, " q"}, quotient, eq);
    check32({name, " r"}, remainder, er);
    @(posedge clk); #2;
    start = 0;
    @(negedge clk);
    check1({name, " done_hold"}, done, 1'b1);
    @(negedge clk);
    check1({name, " done_drop"}, done, 1'b0);
    $display("txn %s: q=0x%08h r=0x%08h stall=%0d", name, quotient, remainder, n_stall);
    @(posedge clk); #2;
  endtask

  task automatic run_div(input string name, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input int estall);
    logic [31:0] rq, rr;
    ref_div(sd, a, b, rq, rr);
    check32({name, " model_q"}, rq, eq);
    check32({name, " model_r"}, rr, er);
    signed_div = sd; dividend = a; divisor = b; start = 1;
    wait_result(name, eq, er, estall, 1'b1);
  endtask

  initial begin
    rst = 1; start = 0; annul = 0; signed_div = 0; dividend = 0; divisor = 0;
    repeat (2) @(posedge clk);
    #2;
    check32("reset q", quotient, 32'd0);
    check32("reset r", remainder, 32'd0);
    check1("reset done", done, 1'b0);
    check1("reset busy", busy, 1'b0);
    rst = 0;
    @(posedge clk); #2;

    run_div("divu_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33);
    run_div("div_m100_7",   1'b1, -32'sd100,      32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  33);
    run_div("div_100_m7",   1'b1, 32'd100,        -32'sd7,        32'hFFFF_FFF2,  32'd2,          33);
    run_div("div_m7_m2",    1'b1, -32'sd7,        -32'sd2,        32'd3,          32'hFFFF_FFFF,  33);
    run_div("div_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33);
    run_div("divu_big",     1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33);
    run_div("divu_80_ff",   1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33);
    run_div("div_by_zero",  1'b1, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  2);

    // annul in the middle of RUN
    signed_div = 0; dividend = 32'd1000; divisor = 32'd7; start = 1;
    repeat (10) begin @(posedge clk); #2; end
    annul = 1;
    #1;
    check1("annul stall", stall_req_ex, 1'b0);
    @(posedge clk); #2;
    annul = 0; start = 0;
    @(negedge clk);
    check1("annul busy", busy, 1'b0);
    check1("annul done", done, 1'b0);
    $display("txn annul: busy=%b done=%b", busy, done);
    @(posedge clk); #2;
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // async reset in the middle of RUN, start held through release
    signed_div = 0; dividend = 32'd100; divisor = 32'd7; start = 1;
    repeat (15) begin @(posedge clk); #2; end
    rst = 1;
    #1;
    check1("rst stall", stall_req_ex, 1'b0);
    check1("rst busy", busy, 1'b0);
    check1("rst done", done, 1'b0);
    check32("rst q", quotient, 32'd0);
    check32("rst r", remainder, 32'd0);
    $display("txn reset: stall=%b busy=%b q=0x%08h", stall_req_ex, busy, quotient);
    #1;
    rst = 0;
    wait_result("restart_100_7", 32'd14, 32'd2, 33, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
